// File: rtl/mul_div_unit.sv
// Execute-stage HI/LO multiply/divide unit: holds architectural HI/LO, runs
// mult/div as fixed-latency busy operations and serves mfhi/mflo reads.
module mul_div_unit #(
    parameter int MUL_CYCLES       = 5,
    parameter int DIV_CYCLES       = 10,
    parameter bit BUSY_ISSUE_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mulCtrl,
    input  logic        mulEnable,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        mulOutputSel,
    output logic        busy,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] mtDisabled         = 3'd0;
    localparam logic [2:0] mtMultiply         = 3'd1;
    localparam logic [2:0] mtMultiplyUnsigned = 3'd2;
    localparam logic [2:0] mtDivide           = 3'd3;
    localparam logic [2:0] mtDivideUnsigned   = 3'd4;
    localparam logic [2:0] mtSetHI            = 3'd5;
    localparam logic [2:0] mtSetLO            = 3'd6;

    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg;
    logic               busy_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2:0]         op_reg;
    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    logic [31:0]        hi_reg;
    logic [31:0]        lo_reg;

    logic [63:0]        prod_next;
    logic               div_signed;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        divisor;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic               wb_en_next;
    logic [31:0]        wb_hi_next;
    logic [31:0]        wb_lo_next;

    // Signed divide works on magnitudes, then restores signs: quotient
    // truncates toward zero and the remainder follows the dividend. This
    // also yields 0x80000000 / -1 = 0x80000000 rem 0 without special casing.
    always_comb begin
        div_signed = (op_reg == mtDivide);
        mag_a      = (div_signed && a_reg[31]) ? (32'd0 - a_reg) : a_reg;
        mag_b      = (div_signed && b_reg[31]) ? (32'd0 - b_reg) : b_reg;
        divisor    = (b_reg == 32'd0) ? 32'd1 : mag_b;
        quo        = mag_a / divisor;
        rem        = mag_a % divisor;
        prod_next  = 64'd0;
        wb_en_next = 1'b0;
        wb_hi_next = hi_reg;
        wb_lo_next = lo_reg;
        case (op_reg)
            mtMultiply: begin
                prod_next  = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
                wb_en_next = 1'b1;
                wb_hi_next = prod_next[63:32];
                wb_lo_next = prod_next[31:0];
            end
            mtMultiplyUnsigned: begin
                prod_next  = {32'd0, a_reg} * {32'd0, b_reg};
                wb_en_next = 1'b1;
                wb_hi_next = prod_next[63:32];
                wb_lo_next = prod_next[31:0];
            end
            mtDivide, mtDivideUnsigned: begin
                // Divide by zero burns the full latency but leaves HI/LO alone.
                wb_en_next = (b_reg != 32'd0);
                wb_lo_next = (div_signed && (a_reg[31] ^ b_reg[31])) ? (32'd0 - quo) : quo;
                wb_hi_next = (div_signed && a_reg[31]) ? (32'd0 - rem) : rem;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            op_reg    <= mtDisabled;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mulEnable) begin
                        case (mulCtrl)
                            mtMultiply, mtMultiplyUnsigned: begin
                                op_reg    <= mulCtrl;
                                a_reg     <= operandA;
                                b_reg     <= operandB;
                                cnt_reg   <= CNT_W'(MUL_CYCLES);
                                state_reg <= RUN;
                                busy_reg  <= 1'b1;
                            end
                            mtDivide, mtDivideUnsigned: begin
                                op_reg    <= mulCtrl;
                                a_reg     <= operandA;
                                b_reg     <= operandB;
                                cnt_reg   <= CNT_W'(DIV_CYCLES);
                                state_reg <= RUN;
                                busy_reg  <= 1'b1;
                            end
                            mtSetHI: hi_reg <= operandA;
                            mtSetLO: lo_reg <= operandA;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // New requests are dropped here; the latched op runs to completion.
                    if (cnt_reg == CNT_W'(1)) begin
                        if (wb_en_next) begin
                            hi_reg <= wb_hi_next;
                            lo_reg <= wb_lo_next;
                        end
                        cnt_reg   <= '0;
                        op_reg    <= mtDisabled;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy   = busy_reg;
    assign hi     = hi_reg;
    assign lo     = lo_reg;
    assign result = mulOutputSel ? hi_reg : lo_reg;

    // The hazard unit is expected to stall D while busy; flag any leak.
    generate
        if (BUSY_ISSUE_CHECK) begin : g_issue_check
            assert property (@(posedge clk) disable iff (!reset) !(busy_reg && mulEnable));
        end
    endgenerate

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Execute-stage HI/LO multiply/divide unit; the consuming end of the decoder's mulCtrl / mulEnable / mulOutputSel interface.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and holds the architectural HI/LO registers.
- Runs multi-cycle operations with a busy flag, which the hazard logic uses to stall mult-class and mfhi/mflo instructions in D.
- Drives the mfhi/mflo read value onto the grfWriteMul path.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥1).

Ports:
- clk  input  1  clock.
- reset  input  1  reset.
- mulCtrl  input  3  operation select; `mt*` encodings from constants.v.
- mulEnable  input  1  operation valid this cycle; equals mulCtrl != `mtDisabled, already gated by bubble/reset upstream.
- operandA  input  32  forwarded rs value (regRead1).
- operandB  input  32  forwarded rt value (regRead2).
- mulOutputSel  input  1  1 = HI, 0 = LO.
- busy  output  1  multi-cycle operation in flight.
- result  output  32  mulOutputSel ? HI : LO, combinational.
- hi  output  32  current HI register, debug.
- lo  output  32  current LO register, debug.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- While reset is low: HI=0, LO=0, busy=0, cycle counter=0, latched operation cleared.
- Reset asserted mid-operation aborts it; no HI/LO write occurs afterwards.
- States: IDLE, RUN.
- Issue (IDLE, rising edge, mulEnable=1, mulCtrl ∈ {mtMultiply, mtMultiplyUnsigned, mtDivide, mtDivideUnsigned}):
  - Latch operandA, operandB and op.
  - Load counter with MUL_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from this edge.
- RUN: counter decrements each edge. On the edge where counter==1:
  - HI/LO are written with the latched result.
  - busy=0 and state returns to IDLE.
  - busy is therefore high for exactly N cycles after the issue edge.
  - An issue is accepted in the first cycle busy=0.
- HI/LO hold their old values throughout RUN; result reflects the old values.
- mthi / mtlo (IDLE, mulEnable=1):
  - HI (or LO) ← operandA at the edge, single cycle, busy stays 0.
  - The other register is unchanged.
  - result shows the new value the following cycle.
- Any mulEnable=1 while busy=1 is ignored; the latched operation is unaffected. The hazard unit must prevent this; assertion in sim.
- mulEnable=0, or unknown mulCtrl: no state change.
- Arithmetic:
  - mult: signed 32×32 → 64; HI = [63:32], LO = [31:0].
  - multu: unsigned 32×32 → 64; same split.
  - div: signed; LO = quotient truncated toward zero, HI = remainder with sign of dividend.
  - div overflow case 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - divu: unsigned quotient → LO, remainder → HI.
  - Divide by zero (div or divu): full busy duration, then HI and LO unchanged.
- result is purely combinational from mulOutputSel and HI/LO; no latency added.

Test Plan:
- mult A=0xFFFFFFFD (-3), B=7 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; result with sel=0 is 0xFFFFFFEB.
- multu A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; re-issue accepted the cycle busy falls.
- div A=0xFFFFFFF9 (-7), B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- divu A=5, B=0 with prior HI=0x11, LO=0x22 → busy 10 cycles; HI=0x11, LO=0x22 afterwards. A mthi issued during busy is ignored.
- mthi A=0x1234 then mtlo A=0x5678 → next cycle result=0x1234 (sel=1) and 0x5678 (sel=0); busy never asserts.
- Start div, pull reset low in cycle 4 → busy=0, HI=LO=0 immediately; after release, no late write; mult 2×3 then yields LO=6, HI=0.
